// File: rtl/led_seq_pkg.sv
// Shared encodings for the LED pattern sequencer: pattern modes and
// the BOUNCE sweep direction.
package led_seq_pkg;

    typedef enum logic [1:0] {
        MODE_BLINK  = 2'b00,
        MODE_SHIFT  = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_FILL   = 2'b11
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

endpackage

// File: rtl/tick_edge_det.sv
// Rising-edge detector for the divided tick, gated by the step enable.
// tick_q resets high so a tick already high at reset release is not
// mistaken for a fresh edge.
module tick_edge_det (
    input  logic clk_i,
    input  logic rst_i,
    input  logic tick_i,
    input  logic en_i,
    output logic step_o
);

    logic tick_q;

    // Track the previous tick level every cycle, independent of enable,
    // so an edge seen while disabled is consumed rather than deferred.
    always_ff @(posedge clk_i) begin
        if (rst_i) tick_q <= 1'b1;
        else       tick_q <= tick_i;
    end

    assign step_o = tick_i & ~tick_q & en_i;

endmodule

// File: rtl/led_pattern_seq.sv
// LED pattern sequencer: steps BLINK / SHIFT / BOUNCE / FILL patterns on
// each enabled rising edge of tick_i. A mode change seen on a step loads
// the new mode's start pattern instead of advancing.
module led_pattern_seq
    import led_seq_pkg::*;
#(
    parameter int N_LEDS = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              tick_i,
    input  logic              en_i,
    input  logic [1:0]        mode_i,
    output logic [N_LEDS-1:0] led_o,
    output logic              step_o,
    output logic              wrap_o
);

    localparam int CW = $clog2(N_LEDS + 1);
    localparam logic [N_LEDS-1:0] ALL_ONES = '1;
    localparam logic [N_LEDS-1:0] BIT0     = N_LEDS'(1);

    logic              step_ev;
    mode_e             mode_q, mode_d, mode_in;
    dir_e              dir_q, dir_d;
    logic [CW-1:0]     count_q, count_d;
    logic [N_LEDS-1:0] led_q, led_d;
    logic              step_q, wrap_q, wrap_d;

    // Lowest n bits set; n may equal N_LEDS, so no shift-and-subtract.
    function automatic logic [N_LEDS-1:0] fill_mask(input logic [CW-1:0] n);
        logic [N_LEDS-1:0] m;
        m = '0;
        for (int i = 0; i < N_LEDS; i++)
            if (i < int'(n)) m[i] = 1'b1;
        return m;
    endfunction

    tick_edge_det u_edge (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .tick_i (tick_i),
        .en_i   (en_i),
        .step_o (step_ev)
    );

    assign mode_in = mode_e'(mode_i);

    // Next-state: mode reload has priority over advancing the pattern.
    always_comb begin
        mode_d  = mode_q;
        dir_d   = dir_q;
        count_d = count_q;
        led_d   = led_q;
        wrap_d  = 1'b0;
        if (step_ev) begin
            if (mode_in != mode_q) begin
                mode_d  = mode_in;
                led_d   = (mode_in == MODE_BLINK) ? ALL_ONES : BIT0;
                dir_d   = DIR_UP;
                count_d = CW'(1);
            end else begin
                case (mode_q)
                    MODE_BLINK: begin
                        led_d  = ~led_q;
                        wrap_d = (led_q == ALL_ONES);
                    end
                    MODE_SHIFT: begin
                        led_d  = {led_q[N_LEDS-2:0], led_q[N_LEDS-1]};
                        wrap_d = led_q[N_LEDS-1];
                    end
                    MODE_BOUNCE: begin
                        case (dir_q)
                            DIR_UP: begin
                                led_d = led_q << 1;
                                // Turn around as soon as the MSB is reached.
                                if (led_q[N_LEDS-2]) dir_d = DIR_DOWN;
                            end
                            DIR_DOWN: begin
                                led_d = led_q >> 1;
                                if (led_q[1]) begin
                                    dir_d  = DIR_UP;
                                    wrap_d = 1'b1;
                                end
                            end
                            default: dir_d = DIR_UP;
                        endcase
                    end
                    MODE_FILL: begin
                        if (count_q == CW'(N_LEDS)) begin
                            count_d = '0;
                            led_d   = '0;
                            wrap_d  = 1'b1;
                        end else begin
                            count_d = count_q + CW'(1);
                            led_d   = fill_mask(count_d);
                        end
                    end
                    default: mode_d = MODE_BLINK;
                endcase
            end
        end
    end

    // State and output registers; reset discards all pattern state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mode_q  <= MODE_BLINK;
            dir_q   <= DIR_UP;
            count_q <= '0;
            led_q   <= '0;
            step_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            dir_q   <= dir_d;
            count_q <= count_d;
            led_q   <= led_d;
            step_q  <= step_ev;
            wrap_q  <= wrap_d;
        end
    end

    assign led_o  = led_q;
    assign step_o = step_q;
    assign wrap_o = wrap_q;

endmodule
